serial_adder: RTL and testbench

//   Bit-serial N-bit adder, LSB first. One 1-bit full-adder cell plus a carry flip-flop

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder.sv | 49 ++++
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    localparam int unsigned SA_STATE_W = 2;

    typedef enum logic [SA_STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sa_state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// 1-bit adder primitives: a half adder and a full adder built from two of them.

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    // Sum is the XOR, carry the AND of the two inputs.
    always_comb begin
        sum_o   = a_i ^ b_i;
        carry_o = a_i & b_i;
    end

endmodule : half_adder

module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .a_i     (a),
        .b_i     (b),
        .sum_o   (s1),
        .carry_o (c1)
    );

    half_adder u_ha1 (
        .a_i     (s1),
        .b_i     (cin),
        .sum_o   (sum),
        .carry_o (c2)
    );

    // At most one half adder can generate a carry, so OR merges them.
    always_comb begin
        cout = c1 | c2;
    end

endmodule : full_adder_bit

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus a carry flop.
// start/busy/done handshake; result held until the next accepted start.

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_e        state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_out_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_c;

    // The single adder cell works on the current LSBs and the stored carry.
    full_adder_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_c)
    );

    // Next sum shift register value: new bit enters at the MSB end.
    always_comb begin
        sum_d = {fa_s, sum_q[WIDTH-1:1]};
    end

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_out_q <= '0;
            cout_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    a_q     <= {1'b0, a_q[WIDTH-1:1]};
                    b_q     <= {1'b0, b_q[WIDTH-1:1]};
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        sum_out_q <= sum_d;
                        cout_q    <= fa_c;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum_out = sum_out_q;
    assign cout    = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): handshake timing and arithmetic.

module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;

    int checks;
    int failures;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held two cycles with start high: everything stays at zero.
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a_in = 8'h5A; b_in = 8'hA5; cin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, sum_out, cout} !== 11'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got busy=%b done=%b sum=%h cout=%b want all 0",
                         i, busy, done, sum_out, cout);
            end
        end
        rst = 1'b0; start = 1'b0;
    endtask

    // One operation from a start pulse; checks busy count, done latency, result.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] exp_sum, input logic exp_cout, input string name);
        int n_busy;
        int lat;
        n_busy = 0;
        lat    = 0;
        @(negedge clk);
        a_in = a; b_in = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in = ~a; b_in = ~b; cin = ~c;
        lat = 1;
        while (!done && lat < 20) begin
            if (busy) n_busy++;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== WIDTH + 1) begin
            failures++;
            $display("FAIL %s_latency got %0d want %0d", name, lat, WIDTH + 1);
        end
        checks++;
        if (n_busy !== WIDTH) begin
            failures++;
            $display("FAIL %s_busy_cycles got %0d want %0d", name, n_busy, WIDTH);
        end
        checks++;
        if ({cout, sum_out} !== {exp_cout, exp_sum}) begin
            failures++;
            $display("FAIL %s_result got cout=%b sum=%h want cout=%b sum=%h",
                     name, cout, sum_out, exp_cout, exp_sum);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || {cout, sum_out} !== {exp_cout, exp_sum}) begin
            failures++;
            $display("FAIL %s_hold got done=%b cout=%b sum=%h want done=0 cout=%b sum=%h",
                     name, done, cout, sum_out, exp_cout, exp_sum);
        end
    endtask

    task automatic test_basic();
        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "add_0f_01");
    endtask

    task automatic test_carry();
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");
    endtask

    // A start pulse during RUN must be ignored.
    task automatic test_start_while_busy();
        int n_done;
        n_done = 0;
        @(negedge clk);
        a_in = 8'h03; b_in = 8'h04; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                checks++;
                if ({cout, sum_out} !== 9'h007) begin
                    failures++;
                    $display("FAIL busy_start_result got cout=%b sum=%h want cout=0 sum=07",
                             cout, sum_out);
                end
            end
        end
        checks++;
        if (n_done !== 1) begin
            failures++;
            $display("FAIL busy_start_done_count got %0d want 1", n_done);
        end
    endtask

    // Reset mid-RUN discards the operation and clears the held result.
    task automatic test_reset_mid_run();
        @(negedge clk);
        a_in = 8'h77; b_in = 8'h11; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum_out !== 8'h00 || cout !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset got busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                     busy, done, sum_out, cout);
        end
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "after_reset");
    endtask

    // Start held high: successive done pulses are WIDTH+2 cycles apart.
    task automatic test_back_to_back();
        int cyc;
        int first;
        int second;
        first = -1; second = -1;
        @(negedge clk);
        a_in = 8'h21; b_in = 8'h12; cin = 1'b1; start = 1'b1;
        for (cyc = 1; cyc < 40 && second < 0; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        start = 1'b0;
        checks++;
        if (first !== WIDTH + 1) begin
            failures++;
            $display("FAIL b2b_first_done got %0d want %0d", first, WIDTH + 1);
        end
        checks++;
        if (second - first !== WIDTH + 2) begin
            failures++;
            $display("FAIL b2b_period got %0d want %0d", second - first, WIDTH + 2);
        end
        checks++;
        if ({cout, sum_out} !== 9'h034) begin
            failures++;
            $display("FAIL b2b_result got cout=%b sum=%h want cout=0 sum=34", cout, sum_out);
        end
        repeat (WIDTH + 3) @(negedge clk);
    endtask

    // Random operand triples against a plain integer sum.
    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [8:0] exp;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            exp = 9'(a) + 9'(b) + 9'(c);
            run_op(a, b, c, exp[7:0], exp[8], $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_adder
